accum_zone_master: RTL

// Initiator for one Accum_Zone slot: drives the Accum_Cmd_If/Accum_Data_If signal set as master.

---
 rtl/accum_zone_master.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/accum_zone_master.sv
// accum_zone_master: slot initiator for the accumulation zone.
// Runs one job descriptor as a stream of write, accumulate or read rows.
module accum_zone_master #(
  parameter int NUM_BANKS     = 4,
  parameter int ADDR_WIDTH    = 9,
  parameter int DATA_WIDTH    = 64,
  parameter int ZONE_WIDTH    = 2,
  parameter int LEN_WIDTH     = 10,
  parameter int RD_FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            job_valid,
  output logic                            job_ready,
  input  logic [1:0]                      job_op,
  input  logic [ADDR_WIDTH-1:0]           job_addr,
  input  logic [LEN_WIDTH-1:0]            job_len,
  input  logic [NUM_BANKS-1:0]            job_mask,
  input  logic [ZONE_WIDTH-1:0]           job_zone,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_BANKS*DATA_WIDTH-1:0] out_data,
  output logic                            done,
  output logic                            busy,
  output logic                            wr_valid,
  input  logic                            wr_ready,
  output logic                            accum_en,
  output logic [NUM_BANKS-1:0]            wr_mask,
  output logic [ADDR_WIDTH-1:0]           wr_addr,
  output logic [ZONE_WIDTH-1:0]           wr_zone_id,
  output logic                            rd_valid,
  input  logic                            rd_ready,
  output logic [NUM_BANKS-1:0]            rd_mask,
  output logic [ADDR_WIDTH-1:0]           rd_addr,
  output logic [ZONE_WIDTH-1:0]           rd_zone_id,
  output logic                            wvalid,
  input  logic                            wready,
  output logic [NUM_BANKS*DATA_WIDTH-1:0] wdata,
  input  logic                            rvalid,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] rdata
);

  localparam int RW = NUM_BANKS * DATA_WIDTH;
  localparam int PW = $clog2(RD_FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(RD_FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                 state;
  logic [1:0]             op_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [LEN_WIDTH-1:0]   rows_q;
  logic [NUM_BANKS-1:0]   mask_q;
  logic [ZONE_WIDTH-1:0]  zone_q;

  logic [CW-1:0]          outst_q;
  logic [CW-1:0]          cnt_q;
  logic [PW-1:0]          wptr_q;
  logic [PW-1:0]          rptr_q;
  logic [RW-1:0]          mem [RD_FIFO_DEPTH];

  logic                   in_hs;
  logic                   wr_hs;
  logic                   w_hs;
  logic                   rd_hs;
  logic                   in_rd;
  logic                   push;
  logic                   pop;
  logic [CW-1:0]          outst_n;
  logic [CW-1:0]          cnt_n;
  logic [CW:0]            credit_n;
  logic [LEN_WIDTH-1:0]   rows_rd_n;

  assign job_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign in_ready  = (state == S_WRITE) && (rows_q != '0)
                   && !wr_valid && !wvalid;

  assign in_hs = in_valid && in_ready;
  assign wr_hs = wr_valid && wr_ready;
  assign w_hs  = wvalid && wready;
  assign rd_hs = rd_valid && rd_ready;

  // Stray returns outside a read job are dropped, not queued.
  assign in_rd = (state == S_READ) || (state == S_DRAIN);
  assign push  = rvalid && in_rd;
  assign pop   = out_valid && out_ready;

  assign out_valid = (cnt_q != '0);
  assign out_data  = mem[rptr_q];

  assign outst_n   = outst_q + CW'(rd_hs) - CW'(push);
  assign cnt_n     = cnt_q + CW'(push) - CW'(pop);
  assign credit_n  = {1'b0, outst_n} + {1'b0, cnt_n};
  assign rows_rd_n = rows_q - LEN_WIDTH'(rd_hs);

  // Job sequencing, command/data channel registers and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      op_q       <= '0;
      addr_q     <= '0;
      rows_q     <= '0;
      mask_q     <= '0;
      zone_q     <= '0;
      done       <= 1'b0;
      wr_valid   <= 1'b0;
      accum_en   <= 1'b0;
      wr_mask    <= '0;
      wr_addr    <= '0;
      wr_zone_id <= '0;
      wvalid     <= 1'b0;
      wdata      <= '0;
      rd_valid   <= 1'b0;
      rd_mask    <= '0;
      rd_addr    <= '0;
      rd_zone_id <= '0;
    end else begin
      done <= 1'b0;
      if (wr_hs) wr_valid <= 1'b0;
      if (w_hs) wvalid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (job_valid) begin
            op_q   <= job_op;
            addr_q <= job_addr;
            rows_q <= job_len;
            mask_q <= job_mask;
            zone_q <= job_zone;
            if (job_op == 2'd3 || job_len == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else if (job_op == 2'd2) begin
              state      <= S_READ;
              rd_valid   <= 1'b1;
              rd_addr    <= job_addr;
              rd_mask    <= job_mask;
              rd_zone_id <= job_zone;
            end else begin
              state <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          if (in_hs) begin
            wr_valid   <= 1'b1;
            wvalid     <= 1'b1;
            wr_addr    <= addr_q;
            wr_mask    <= mask_q;
            wr_zone_id <= zone_q;
            accum_en   <= (op_q == 2'd1);
            wdata      <= in_data;
            addr_q     <= addr_q + ADDR_WIDTH'(1);
            rows_q     <= rows_q - LEN_WIDTH'(1);
          end else if (rows_q == '0 && !wr_valid && !wvalid) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_READ: begin
          if (rd_hs) begin
            rd_addr <= rd_addr + ADDR_WIDTH'(1);
            rows_q  <= rows_rd_n;
          end
          if (rd_hs && rows_q == LEN_WIDTH'(1)) begin
            state    <= S_DRAIN;
            rd_valid <= 1'b0;
          end else begin
            rd_valid <= (rows_rd_n != '0) && (credit_n < DEPTH_C);
          end
        end
        S_DRAIN: begin
          if (outst_q == '0 && cnt_q == '0) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Outstanding-read tracking and read-return FIFO pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      outst_q <= '0;
      cnt_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      outst_q <= outst_n;
      cnt_q   <= cnt_n;
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop) rptr_q <= rptr_q + PW'(1);
    end
  end

  // Read-return storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= rdata;
  end

endmodule
